// File: rtl/obj_pkg.sv
// -----------------------------------------------------------------------------
// obj_pkg
// Shared definitions for the object compositor.
//   COLOR_W    : packed {R,G,B} colour width, CH_W bits per channel
//   BG_DEFAULT : default background colour
//   color_r/g/b: extract one channel from a packed colour
// -----------------------------------------------------------------------------
package obj_pkg;

    localparam int COLOR_W = 12;
    localparam int CH_W    = 4;

    localparam logic [COLOR_W-1:0] BG_DEFAULT = 12'h000;

    function automatic logic [CH_W-1:0] color_r(input logic [COLOR_W-1:0] c);
        return c[3*CH_W-1 -: CH_W];
    endfunction

    function automatic logic [CH_W-1:0] color_g(input logic [COLOR_W-1:0] c);
        return c[2*CH_W-1 -: CH_W];
    endfunction

    function automatic logic [CH_W-1:0] color_b(input logic [COLOR_W-1:0] c);
        return c[CH_W-1 -: CH_W];
    endfunction

endpackage

// File: rtl/obj_hit_test.sv
// -----------------------------------------------------------------------------
// obj_hit_test
// One object's frame-shadowed bounding box, colour and visibility, plus the
// strict inside test against the current pixel.
//   i_clk, i_rst       : clock, async active-high reset
//   i_frame_start      : latch bounds/colour/swap/visibility into the shadows
//   i_x, i_y           : current pixel position
//   i_score, i_thresh  : object visible for the frame iff score > thresh
//   i_x1..i_y2         : live box bounds
//   i_color, i_swap_xy : live colour and rotated-compare select
//   o_hit              : pixel strictly inside the shadowed box and visible
//   o_vis              : shadowed visibility
//   o_color            : shadowed colour
// -----------------------------------------------------------------------------
module obj_hit_test
    import obj_pkg::*;
#(
    parameter int COORD_W = 12,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int SCORE_W = 9
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame_start,
    input  logic [X_W-1:0]     i_x,
    input  logic [Y_W-1:0]     i_y,
    input  logic [SCORE_W-1:0] i_score,
    input  logic [SCORE_W-1:0] i_thresh,
    input  logic [COORD_W-1:0] i_x1,
    input  logic [COORD_W-1:0] i_x2,
    input  logic [COORD_W-1:0] i_y1,
    input  logic [COORD_W-1:0] i_y2,
    input  logic [COLOR_W-1:0] i_color,
    input  logic               i_swap_xy,
    output logic               o_hit,
    output logic               o_vis,
    output logic [COLOR_W-1:0] o_color
);

    logic [COORD_W-1:0] r_x1, r_x2, r_y1, r_y2;
    logic [COLOR_W-1:0] r_color;
    logic               r_swap;
    logic               r_vis;

    logic [COORD_W-1:0] w_xe, w_ye, w_px, w_py;
    logic               w_in;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x1    <= '0;
            r_x2    <= '0;
            r_y1    <= '0;
            r_y2    <= '0;
            r_color <= '0;
            r_swap  <= 1'b0;
            r_vis   <= 1'b0;
        end else if (i_frame_start) begin
            r_x1    <= i_x1;
            r_x2    <= i_x2;
            r_y1    <= i_y1;
            r_y2    <= i_y2;
            r_color <= i_color;
            r_swap  <= i_swap_xy;
            r_vis   <= (i_score > i_thresh);
        end
    end

    assign w_xe = COORD_W'(i_x);
    assign w_ye = COORD_W'(i_y);

    // Rotated objects compare the screen y against their x bounds and vice versa.
    assign w_px = r_swap ? w_ye : w_xe;
    assign w_py = r_swap ? w_xe : w_ye;

    assign w_in = (w_px > r_x1) && (w_px < r_x2) && (w_py > r_y1) && (w_py < r_y2);

    assign o_hit   = w_in & r_vis;
    assign o_vis   = r_vis;
    assign o_color = r_color;

endmodule

// File: rtl/obj_compositor.sv
// -----------------------------------------------------------------------------
// obj_compositor
// N-object rectangle compositor: fixed-priority colour select (object 0
// highest), score-gated visibility and per-frame collision mask against
// object 0.
//   i_clk, i_rst        : clock, async active-high reset
//   i_pix_stb           : pixel enable; pipeline advances only when high
//   i_frame_start       : frame boundary pulse; latches shadows, publishes hits
//   i_x, i_y            : current pixel position
//   i_score             : current score
//   i_obj_x1/x2/y1/y2   : packed box bounds, object k at [k*COORD_W +: COORD_W]
//   i_obj_thresh        : packed visibility thresholds
//   i_obj_color         : packed per-object colour {R,G,B}
//   i_obj_swap_xy       : per-object rotated compare
//   o_r, o_g, o_b       : registered pixel colour, two strobes after the pixel
//   o_hit_mask          : objects that overlapped object 0 in the last frame
//   o_hit_valid         : one-cycle pulse when o_hit_mask updates
//   o_vis_mask          : visibility mask of the current frame
// -----------------------------------------------------------------------------
module obj_compositor
    import obj_pkg::*;
#(
    parameter int                 N_OBJ    = 8,
    parameter int                 COORD_W  = 12,
    parameter int                 X_W      = 10,
    parameter int                 Y_W      = 9,
    parameter int                 SCORE_W  = 9,
    parameter logic [COLOR_W-1:0] BG_COLOR = BG_DEFAULT
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_pix_stb,
    input  logic                       i_frame_start,
    input  logic [X_W-1:0]             i_x,
    input  logic [Y_W-1:0]             i_y,
    input  logic [SCORE_W-1:0]         i_score,
    input  logic [N_OBJ*COORD_W-1:0]   i_obj_x1,
    input  logic [N_OBJ*COORD_W-1:0]   i_obj_x2,
    input  logic [N_OBJ*COORD_W-1:0]   i_obj_y1,
    input  logic [N_OBJ*COORD_W-1:0]   i_obj_y2,
    input  logic [N_OBJ*SCORE_W-1:0]   i_obj_thresh,
    input  logic [N_OBJ*COLOR_W-1:0]   i_obj_color,
    input  logic [N_OBJ-1:0]           i_obj_swap_xy,
    output logic [CH_W-1:0]            o_r,
    output logic [CH_W-1:0]            o_g,
    output logic [CH_W-1:0]            o_b,
    output logic [N_OBJ-1:0]           o_hit_mask,
    output logic                       o_hit_valid,
    output logic [N_OBJ-1:0]           o_vis_mask
);

    logic [N_OBJ-1:0]   w_hit;
    logic [N_OBJ-1:0]   w_vis;
    logic [COLOR_W-1:0] w_color [N_OBJ];
    logic [COLOR_W-1:0] w_sel_color;
    logic [N_OBJ-1:1]   w_acc_set;

    logic [N_OBJ-1:0]   r_hit_s1;
    logic [COLOR_W-1:0] r_color;
    logic [N_OBJ-1:1]   r_acc;
    logic [N_OBJ-1:0]   r_hit_mask;
    logic               r_hit_valid;

    for (genvar k = 0; k < N_OBJ; k++) begin : g_obj
        obj_hit_test #(
            .COORD_W (COORD_W),
            .X_W     (X_W),
            .Y_W     (Y_W),
            .SCORE_W (SCORE_W)
        ) u_hit (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_frame_start (i_frame_start),
            .i_x           (i_x),
            .i_y           (i_y),
            .i_score       (i_score),
            .i_thresh      (i_obj_thresh[k*SCORE_W +: SCORE_W]),
            .i_x1          (i_obj_x1[k*COORD_W +: COORD_W]),
            .i_x2          (i_obj_x2[k*COORD_W +: COORD_W]),
            .i_y1          (i_obj_y1[k*COORD_W +: COORD_W]),
            .i_y2          (i_obj_y2[k*COORD_W +: COORD_W]),
            .i_color       (i_obj_color[k*COLOR_W +: COLOR_W]),
            .i_swap_xy     (i_obj_swap_xy[k]),
            .o_hit         (w_hit[k]),
            .o_vis         (w_vis[k]),
            .o_color       (w_color[k])
        );
    end

    // Scan from the lowest priority upward so the lowest set index wins.
    always_comb begin
        w_sel_color = BG_COLOR;
        for (int k = N_OBJ - 1; k >= 0; k--) begin
            if (r_hit_s1[k]) begin
                w_sel_color = w_color[k];
            end
        end
    end

    assign w_acc_set = r_hit_s1[0] ? r_hit_s1[N_OBJ-1:1] : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hit_s1    <= '0;
            r_color     <= '0;
            r_acc       <= '0;
            r_hit_mask  <= '0;
            r_hit_valid <= 1'b0;
        end else begin
            r_hit_valid <= i_frame_start;
            if (i_pix_stb) begin
                r_hit_s1 <= w_hit;
                r_color  <= w_sel_color;
            end
            // An overlap on the publishing edge lands in the fresh accumulator.
            if (i_frame_start) begin
                r_hit_mask <= {r_acc, 1'b0};
                r_acc      <= i_pix_stb ? w_acc_set : '0;
            end else if (i_pix_stb) begin
                r_acc <= r_acc | w_acc_set;
            end
        end
    end

    assign o_r         = color_r(r_color);
    assign o_g         = color_g(r_color);
    assign o_b         = color_b(r_color);
    assign o_hit_mask  = r_hit_mask;
    assign o_hit_valid = r_hit_valid;
    assign o_vis_mask  = w_vis;

endmodule

// File: tb/tb_obj_compositor.sv
`timescale 1ns/1ps
module tb_obj_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_pix_stb;
    logic        i_frame_start;
    logic [9:0]  i_x;
    logic [8:0]  i_y;
    logic [8:0]  i_score;
    logic [95:0] i_obj_x1, i_obj_x2, i_obj_y1, i_obj_y2;
    logic [71:0] i_obj_thresh;
    logic [95:0] i_obj_color;
    logic [7:0]  i_obj_swap_xy;
    logic [3:0]  o_r, o_g, o_b;
    logic [7:0]  o_hit_mask;
    logic        o_hit_valid;
    logic [7:0]  o_vis_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obj_compositor dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pix_stb     (i_pix_stb),
        .i_frame_start (i_frame_start),
        .i_x           (i_x),
        .i_y           (i_y),
        .i_score       (i_score),
        .i_obj_x1      (i_obj_x1),
        .i_obj_x2      (i_obj_x2),
        .i_obj_y1      (i_obj_y1),
        .i_obj_y2      (i_obj_y2),
        .i_obj_thresh  (i_obj_thresh),
        .i_obj_color   (i_obj_color),
        .i_obj_swap_xy (i_obj_swap_xy),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_hit_mask    (o_hit_mask),
        .o_hit_valid   (o_hit_valid),
        .o_vis_mask    (o_vis_mask)
    );

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_obj(input int k, input logic [11:0] x1, input logic [11:0] y1,
                           input logic [11:0] x2, input logic [11:0] y2,
                           input logic [11:0] col, input logic [8:0] th, input logic sw);
        i_obj_x1[k*12 +: 12]   = x1;
        i_obj_y1[k*12 +: 12]   = y1;
        i_obj_x2[k*12 +: 12]   = x2;
        i_obj_y2[k*12 +: 12]   = y2;
        i_obj_color[k*12 +: 12] = col;
        i_obj_thresh[k*9 +: 9] = th;
        i_obj_swap_xy[k]       = sw;
    endtask

    task automatic scene_a();
        set_obj(0, 100, 100, 120, 120, 12'hFFF, 0, 0);
        set_obj(1, 200, 600, 300, 640, 12'h0F0, 0, 1);
        set_obj(2, 130, 130, 170, 170, 12'h00F, 0, 0);
        set_obj(3, 150, 150, 190, 190, 12'hF00, 30, 0);
        set_obj(4, 400, 10, 401, 20, 12'h0FF, 0, 0);
        set_obj(5, 410, 10, 412, 20, 12'hF0F, 0, 0);
        set_obj(6, 0, 0, 0, 0, 12'h123, 0, 0);
        set_obj(7, 0, 0, 0, 0, 12'h456, 0, 0);
    endtask

    task automatic scene_b();
        set_obj(0, 140, 140, 160, 160, 12'hF00, 0, 0);
        set_obj(1, 145, 145, 170, 170, 12'h0F0, 0, 0);
        for (int k = 2; k < 8; k++) set_obj(k, 0, 0, 0, 0, 12'h000, 0, 0);
    endtask

    // Present a pixel for two strobes, idle one cycle, then return the colour.
    task automatic pixel(input logic [9:0] x, input logic [8:0] y, output logic [11:0] c);
        @(negedge clk); i_x = x; i_y = y; i_pix_stb = 1'b1;
        @(negedge clk); i_pix_stb = 1'b1;
        @(negedge clk); i_pix_stb = 1'b0;
        @(negedge clk);
        c = {o_r, o_g, o_b};
    endtask

    task automatic frame_pulse(input logic stb);
        @(negedge clk); i_frame_start = 1'b1; i_pix_stb = stb;
        @(negedge clk); i_frame_start = 1'b0; i_pix_stb = 1'b0;
    endtask

    logic [11:0] c;

    initial begin
        rst = 1'b1; i_pix_stb = 0; i_frame_start = 0; i_x = 0; i_y = 0; i_score = 0;
        i_obj_x1 = '0; i_obj_x2 = '0; i_obj_y1 = '0; i_obj_y2 = '0;
        i_obj_thresh = '0; i_obj_color = '0; i_obj_swap_xy = '0;

        vecs[0]  = '{x:10'd110, y:9'd110, exp:12'hFFF};
        vecs[1]  = '{x:10'd100, y:9'd110, exp:12'h000};
        vecs[2]  = '{x:10'd120, y:9'd110, exp:12'h000};
        vecs[3]  = '{x:10'd101, y:9'd101, exp:12'hFFF};
        vecs[4]  = '{x:10'd119, y:9'd119, exp:12'hFFF};
        vecs[5]  = '{x:10'd610, y:9'd250, exp:12'h0F0};
        vecs[6]  = '{x:10'd620, y:9'd300, exp:12'h000};
        vecs[7]  = '{x:10'd639, y:9'd201, exp:12'h0F0};
        vecs[8]  = '{x:10'd160, y:9'd160, exp:12'h00F};
        vecs[9]  = '{x:10'd180, y:9'd180, exp:12'hF00};
        vecs[10] = '{x:10'd400, y:9'd15,  exp:12'h000};
        vecs[11] = '{x:10'd401, y:9'd15,  exp:12'h000};
        vecs[12] = '{x:10'd411, y:9'd15,  exp:12'hF0F};
        vecs[13] = '{x:10'd410, y:9'd15,  exp:12'h000};
        vecs[14] = '{x:10'd0,   y:9'd0,   exp:12'h000};

        repeat (3) @(negedge clk);
        check("reset_color", {o_r, o_g, o_b}, 12'h000);
        check("reset_hit_mask", 12'(o_hit_mask), 12'h000);
        check("reset_hit_valid", 12'(o_hit_valid), 12'h000);
        check("reset_vis", 12'(o_vis_mask), 12'h000);
        rst = 1'b0;

        scene_a();
        i_score = 9'd31;
        pixel(10'd110, 9'd110, c);
        check("no_draw_before_frame", c, 12'h000);
        frame_pulse(1'b0);
        check("vis_a", 12'(o_vis_mask), 12'h0FF);
        check("first_valid", 12'(o_hit_valid), 12'h001);
        check("first_mask", 12'(o_hit_mask), 12'h000);
        @(negedge clk);
        check("first_valid_drop", 12'(o_hit_valid), 12'h000);

        for (int i = 0; i < 15; i++) begin
            pixel(vecs[i].x, vecs[i].y, c);
            check($sformatf("vec%0d", i), c, vecs[i].exp);
        end

        // Exact two-strobe latency: one strobe of a new pixel still shows the old one.
        pixel(10'd110, 9'd110, c);
        @(negedge clk); i_x = 10'd0; i_y = 9'd0; i_pix_stb = 1'b1;
        @(negedge clk); i_pix_stb = 1'b0;
        check("latency_one_strobe", {o_r, o_g, o_b}, 12'hFFF);
        @(negedge clk); i_pix_stb = 1'b1;
        @(negedge clk); i_pix_stb = 1'b0;
        check("latency_two_strobes", {o_r, o_g, o_b}, 12'h000);

        // Score threshold gating, frame-synchronous.
        i_score = 9'd30;
        frame_pulse(1'b0);
        check("vis_thresh_eq", 12'(o_vis_mask), 12'h0F7);
        pixel(10'd180, 9'd180, c);
        check("obj3_hidden", c, 12'h000);
        i_score = 9'd31;
        pixel(10'd180, 9'd180, c);
        check("score_midframe_hidden", c, 12'h000);
        check("vis_midframe", 12'(o_vis_mask), 12'h0F7);
        frame_pulse(1'b0);
        check("vis_thresh_gt", 12'(o_vis_mask), 12'h0FF);
        pixel(10'd180, 9'd180, c);
        check("obj3_shown", c, 12'hF00);
        i_score = 9'd30;
        pixel(10'd180, 9'd180, c);
        check("score_drop_midframe", c, 12'hF00);

        // Bounds change without frame_start must not tear.
        i_obj_x1[11:0] = 12'd115;
        pixel(10'd110, 9'd110, c);
        check("bounds_midframe", c, 12'hFFF);

        // Priority and collision publish.
        scene_b();
        frame_pulse(1'b0);
        pixel(10'd150, 9'd150, c);
        check("priority_obj0", c, 12'hF00);
        pixel(10'd165, 9'd165, c);
        check("obj1_only", c, 12'h0F0);
        frame_pulse(1'b0);
        check("collide_mask", 12'(o_hit_mask), 12'h002);
        check("collide_valid", 12'(o_hit_valid), 12'h001);
        @(negedge clk);
        check("collide_valid_drop", 12'(o_hit_valid), 12'h000);
        check("collide_mask_hold", 12'(o_hit_mask), 12'h002);

        // Overlap on the publishing edge counts toward the next frame.
        frame_pulse(1'b0);
        check("clear_mask", 12'(o_hit_mask), 12'h000);
        pixel(10'd0, 9'd0, c);
        @(negedge clk); i_x = 10'd150; i_y = 9'd150; i_pix_stb = 1'b1;
        @(negedge clk); i_pix_stb = 1'b1; i_frame_start = 1'b1;
        @(negedge clk); i_pix_stb = 1'b0; i_frame_start = 1'b0;
        check("coincide_mask", 12'(o_hit_mask), 12'h000);
        check("coincide_valid", 12'(o_hit_valid), 12'h001);
        frame_pulse(1'b0);
        check("next_frame_mask", 12'(o_hit_mask), 12'h002);

        // Async reset between edges mid-frame.
        pixel(10'd150, 9'd150, c);
        check("pre_reset_color", c, 12'hF00);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("async_rst_color", {o_r, o_g, o_b}, 12'h000);
        check("async_rst_mask", 12'(o_hit_mask), 12'h000);
        check("async_rst_vis", 12'(o_vis_mask), 12'h000);
        check("async_rst_valid", 12'(o_hit_valid), 12'h000);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_valid", 12'(o_hit_valid), 12'h000);
        end
        rst = 1'b0;
        pixel(10'd150, 9'd150, c);
        check("post_reset_no_draw", c, 12'h000);
        check("post_reset_valid", 12'(o_hit_valid), 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obj_compositor.md
Name: obj_compositor

Overview:
Parametrised N-object rectangle compositor replacing the hard-wired per-object compare/OR logic in the game top level. It takes the current pixel position from the VGA timing block and the bounding boxes of N objects (ball, paddles, decoys). It outputs a registered 4:4:4 colour with fixed priority and per-object colour. It also gates object visibility on score thresholds and reports per-frame pixel-overlap collisions against object 0 (the ball).

Parameters:
N_OBJ, 8, number of objects; index 0 is the primary ball and the highest draw priority
COORD_W, 12, width of each bounding-box coordinate
X_W, 10, pixel x width
Y_W, 9, pixel y width
SCORE_W, 9, score width
BG_COLOR, 12'h000, background colour {R,G,B}, 4 bits each

Ports:
i_clk  in  1  system clock (100 MHz)
i_rst  in  1  asynchronous, active-high reset
i_pix_stb  in  1  pixel clock enable; all pipeline stages advance only when high
i_frame_start  in  1  one-cycle pulse at end of active drawing (animate)
i_x  in  X_W  current pixel x
i_y  in  Y_W  current pixel y
i_score  in  SCORE_W  current score
i_obj_x1, i_obj_x2, i_obj_y1, i_obj_y2  in  N_OBJ*COORD_W each  packed box bounds; object k occupies bits [k*COORD_W +: COORD_W]
i_obj_thresh  in  N_OBJ*SCORE_W  object k is visible iff i_score > thresh_k
i_obj_color  in  N_OBJ*12  per-object colour {R,G,B}
i_obj_swap_xy  in  N_OBJ  1 = compare i_y against the x bounds and i_x against the y bounds (rotated paddle)
o_r, o_g, o_b  out  4 each  registered pixel colour
o_hit_mask  out  N_OBJ  collision mask for the previous frame; bit 0 is always 0
o_hit_valid  out  1  one-cycle pulse when o_hit_mask updates
o_vis_mask  out  N_OBJ  registered visibility mask for the current frame

Behaviour:
- Reset: async, active-high. Effects:
  - o_r, o_g and o_b are 0, o_hit_mask is 0, o_hit_valid is 0, and o_vis_mask is 0.
  - All shadow registers and pipeline registers clear to 0.
- Shadow latch: on an i_clk edge with i_frame_start=1, the following are latched into shadow registers: all box bounds, colours and swap bits, plus vis_k = (i_score > thresh_k) (unsigned, strict). o_vis_mask takes the new vis in the same edge. Compares use only the shadow values, so there is no mid-frame tearing. Shadow bounds are 0 after reset, so no object is drawn until the first frame_start.
- Inside test: in_k = (px > x1) & (px < x2) & (py > y1) & (py < y2). All inequalities are strict and unsigned. px and py are zero-extended to COORD_W. When swap_k=1, px=i_y and py=i_x; otherwise px=i_x and py=i_y. hit_k = in_k & vis_k.
- Stage 1 (on i_pix_stb): register the hit vector.
- Stage 2 (on i_pix_stb): the lowest-index set bit of the stage-1 hit vector selects its colour. If no bit is set, BG_COLOR is selected. Register the result to o_r, o_g, o_b.
- Latency: exactly 2 i_pix_stb strobes from pixel (x,y) presented to its colour on the outputs. Outputs hold between strobes.
- Collision accumulator acc[N_OBJ-1:1]: on each i_pix_stb where stage-1 bit 0 is set and stage-1 bit k is set, acc[k] is set (sticky).
- Frame end, on i_frame_start:
  - o_hit_mask <= {acc, 1'b0}, o_hit_valid <= 1 for one cycle, and acc is cleared.
  - If a pixel overlap and i_frame_start coincide on the same edge, the overlap is recorded in the cleared accumulator, i.e. it counts toward the next frame. It does not appear in the mask being published.
- If i_frame_start and i_pix_stb coincide, both actions occur; the pipeline uses the old shadow values for that strobe.
- Degenerate boxes (x2 <= x1+1) never draw.
- Reset asserted mid-frame: outputs go to 0 immediately, and no o_hit_valid pulse is emitted.

Decomposition:
- Shared package obj_pkg: COLOR_W=12, per-channel width 4, BG default, and functions to slice packed object vectors.
- One natural sub-module, obj_hit_test, instantiated N_OBJ times by a generate loop. It holds one object's shadow registers, swap muxing, strict compares and visibility, and outputs hit_k.
- The priority encoder, colour mux and collision accumulator stay in obj_compositor.

Test Plan:
1. Reset, then object0 box (100,100)-(120,120), colour FFF, thresh 0, score 1, then one frame_start. Pixel (110,110) gives FFF two strobes later; pixel (100,110) gives 000 (strict edge).
2. Objects 0 and 1 overlap at (150,150) with colours F00 and 0F0. Output is F00 (priority). At the next frame_start, o_hit_mask=0000_0010 and o_hit_valid pulses exactly 1 cycle.
3. Object 3 with thresh 30: score 30 makes it invisible (o_vis_mask[3]=0, background drawn). Score 31 plus frame_start makes it visible. A score change mid-frame has no effect until frame_start.
4. Object 1 with swap_xy=1 and bounds x 200-300, y 600-640. Pixel (x=610, y=250) is drawn; pixel (x=250, y=610) is not.
5. Bounds changed mid-frame with no frame_start: output is unchanged. Overlap on the same edge as frame_start: the published mask is 0, and the next mask has the bit set.
6. Async reset asserted between clock edges mid-frame: o_r/g/b, o_hit_mask and o_vis_mask are 0 immediately, with no o_hit_valid pulse.
